// File: rtl/uart_ram_dump.sv
// Streams a block of RAM out of an 8N1 UART (LSB first) while holding the CPU off the RAM.
// Define UART_DUMP_CHECKSUM_EN to append a two's-complement checksum trailer frame.
module uart_ram_dump #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int RAM_SETTLE = 2
) (
  input  logic        clk_ram,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] length,
  output logic [15:0] raddr,
  input  logic [7:0]  rdata,
  output logic        ask_for_ram,
  output logic        serial_txd,
  output logic        busy,
  output logic        done
);

  localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(RAM_SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_SEND    = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] raddr_q, raddr_d;
  logic [15:0] baud_q, baud_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  bit_q, bit_d;
  logic        txd_q, txd_d;
  logic        ask_q, ask_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        trl_pending_s;

`ifdef UART_DUMP_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic        trl_q, trl_d;
  assign trl_pending_s = ~trl_q;
`else
  assign trl_pending_s = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= 16'd0;
      rem_q   <= 16'd0;
      raddr_q <= 16'd0;
      baud_q  <= 16'd0;
      shift_q <= 8'd0;
      bit_q   <= 4'd0;
      txd_q   <= 1'b1;
      ask_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
      sum_q   <= 8'd0;
      trl_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      raddr_q <= raddr_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      ask_q   <= ask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_DUMP_CHECKSUM_EN
      sum_q   <= sum_d;
      trl_q   <= trl_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    raddr_d = raddr_q;
    baud_d  = baud_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    txd_d   = txd_q;
    ask_d   = ask_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef UART_DUMP_CHECKSUM_EN
    sum_d   = sum_q;
    trl_d   = trl_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          rem_d   = length;
          busy_d  = 1'b1;
          ask_d   = 1'b1;
          baud_d  = 16'd0;
          bit_d   = 4'd0;
          state_d = S_SETTLE;
`ifdef UART_DUMP_CHECKSUM_EN
          sum_d   = 8'd0;
          trl_d   = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      // The baud counter doubles as the CPU-halt settle timer.
      S_SETTLE: begin
        if (baud_q == SETTLE_LAST) begin
          baud_d = 16'd0;
          if ((rem_q != 16'd0) || trl_pending_s) begin
            raddr_d = addr_q;
            state_d = S_RD_ADDR;
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      S_RD_ADDR: begin
        state_d = S_RD_DATA;
      end

      S_RD_DATA: begin
        baud_d  = 16'd0;
        bit_d   = 4'd0;
        txd_d   = 1'b0;
        state_d = S_SEND;
        if (rem_q != 16'd0) begin
          shift_d = rdata;
          addr_d  = addr_q + 16'd1;
          rem_d   = rem_q - 16'd1;
`ifdef UART_DUMP_CHECKSUM_EN
          sum_d   = sum_q + rdata;
`endif
        end else begin
`ifdef UART_DUMP_CHECKSUM_EN
          shift_d = 8'd0 - sum_q;
          trl_d   = 1'b1;
`else
          shift_d = shift_q;
`endif
        end
      end

      // bit_q: 0 = start, 1..8 = data, 9 = stop; the shifter always presents the next data bit.
      S_SEND: begin
        if (baud_q == BIT_LAST) begin
          baud_d = 16'd0;
          if (bit_q == 4'd9) begin
            if ((rem_q != 16'd0) || trl_pending_s) begin
              raddr_d = addr_q;
              state_d = S_RD_ADDR;
            end else begin
              done_d  = 1'b1;
              ask_d   = 1'b0;
              busy_d  = 1'b0;
              state_d = S_FINISH;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            txd_d   = (bit_q == 4'd8) ? 1'b1 : shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      // Entered with done already set after a frame, or with it clear for an empty dump.
      S_FINISH: begin
        if (done_q) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          done_d  = 1'b1;
          ask_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign raddr       = raddr_q;
  assign ask_for_ram = ask_q;
  assign serial_txd  = txd_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_uart_ram_dump.sv
// Scoreboard bench for uart_ram_dump: a reference model queues expected bytes, a UART monitor decodes and compares.
module tb_uart_ram_dump;

  logic        clk_ram = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] length;
  logic [15:0] raddr;
  logic [7:0]  rdata;
  logic        ask_for_ram;
  logic        serial_txd;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:65535];
  logic [7:0]  exp_q [$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  uart_ram_dump #(
    .CLK_HZ    (1000000),
    .BAUD      (250000),
    .RAM_SETTLE(2)
  ) dut (
    .clk_ram    (clk_ram),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .raddr      (raddr),
    .rdata      (rdata),
    .ask_for_ram(ask_for_ram),
    .serial_txd (serial_txd),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_ram = ~clk_ram;

  always @(posedge clk_ram) begin
    cyc   <= cyc + 1;
    rdata <= mem[raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial monitor: decodes each 4-clock-per-bit frame and checks it against the scoreboard.
  initial begin : monitor
    int         m_cnt;
    bit         m_act;
    bit         m_ok;
    logic       cur;
    logic [7:0] m_byte;
    bit         gap_arm;
    int         gap_cnt;
    logic [7:0] e;
    m_cnt = 0; m_act = 0; m_ok = 1; cur = 1'b1; m_byte = 8'd0; gap_arm = 0; gap_cnt = 0;
    forever begin
      @(negedge clk_ram);
      if (!reset_n) begin
        m_act   = 0;
        gap_arm = 0;
      end else if (!m_act) begin
        if (serial_txd === 1'b0) begin
          if (gap_arm) check("frame_gap", gap_cnt, 2);
          gap_arm = 0;
          m_act   = 1;
          m_cnt   = 1;
          m_ok    = 1;
          cur     = 1'b0;
        end else if (done === 1'b1) begin
          gap_arm = 0;
        end else begin
          gap_cnt++;
        end
      end else begin
        if (m_cnt % 4 == 0) begin
          cur = serial_txd;
          if (m_cnt / 4 >= 1 && m_cnt / 4 <= 8) m_byte[m_cnt / 4 - 1] = serial_txd;
        end else if (serial_txd !== cur) begin
          m_ok = 0;
        end
        if (m_cnt == 39) begin
          check("frame_shape_stop", {m_ok, cur}, 2'b11);
          check("frame_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_byte", m_byte, e);
          end
          m_act   = 0;
          gap_arm = 1;
          gap_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Reference model: bytes come straight from the RAM image; timing from frame count.
  task automatic run_dump(input logic [15:0] a, input logic [15:0] n, input bit poke);
    logic [7:0]  sum;
    logic [15:0] ad;
    int frames, done_exp, rel, first_low, t0;
    bit hold_ok, got_done;
    sum = 8'd0;
    frames = n;
    for (int i = 0; i < n; i++) begin
      ad = a + 16'(i);
      exp_q.push_back(mem[ad]);
      sum = sum + mem[ad];
    end
`ifdef UART_DUMP_CHECKSUM_EN
    exp_q.push_back(8'd0 - sum);
    frames++;
`endif
    done_exp = (frames == 0) ? 4 : 3 + 42 * frames;
    @(negedge clk_ram);
    start = 1'b1; start_addr = a; length = n; t0 = cyc;
    @(negedge clk_ram);
    start = 1'b0; start_addr = 16'($urandom); length = 16'($urandom);
    check("ask_busy_rise", {ask_for_ram, busy}, 2'b11);
    rel = 1; first_low = -1; hold_ok = 1; got_done = 0;
    while (!got_done && rel < done_exp + 20) begin
      @(negedge clk_ram);
      rel = cyc - t0;
      start = poke && (rel == 20);
      if (start) begin
        start_addr = a ^ 16'h5555;
        length     = n + 16'd3;
      end
      if (done === 1'b1) got_done = 1;
      else if (!(ask_for_ram === 1'b1 && busy === 1'b1)) hold_ok = 0;
      if (serial_txd === 1'b0 && first_low < 0) first_low = rel;
    end
    start = 1'b0;
    check("done_seen", got_done, 1'b1);
    check("done_cycle", rel, done_exp);
    check("ask_busy_held", hold_ok, 1'b1);
    check("release_at_done", {ask_for_ram, busy}, 2'b00);
    check("first_start_bit", first_low, (frames > 0) ? 5 : -1);
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk_ram);
    check("done_one_cycle", done, 1'b0);
  endtask

  task automatic reset_mid_frame(input logic [15:0] a);
    @(negedge clk_ram);
    exp_q.push_back(mem[a]);
    start = 1'b1; start_addr = a; length = 16'd2;
    @(negedge clk_ram);
    start = 1'b0;
    repeat (21) @(negedge clk_ram);
    check("data_bit3_on_line", serial_txd, mem[a][3]);
    reset_n = 1'b0;
    #1;
    check("async_rst_outputs", {serial_txd, ask_for_ram, busy, done}, 4'b1000);
    check("async_rst_raddr", raddr, 16'h0000);
    repeat (2) @(negedge clk_ram);
    exp_q.delete();
    reset_n = 1'b1;
    repeat (2) @(negedge clk_ram);
    check("idle_after_rst", {serial_txd, busy}, 2'b10);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] ra;
    logic [15:0] rn;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    reset_n = 1'b0; start = 1'b0; start_addr = 16'd0; length = 16'd0;
    repeat (3) @(negedge clk_ram);
    check("reset_outputs", {serial_txd, ask_for_ram, busy, done}, 4'b1000);
    check("reset_raddr", raddr, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk_ram);

    mem[16'h0600] = 8'hA5;
    run_dump(16'h0600, 16'd1, 1'b0);

    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33;
    run_dump(16'hFFFE, 16'd3, 1'b0);

    run_dump(16'h4321, 16'd0, 1'b0);

    run_dump(16'h1234, 16'd2, 1'b1);

    reset_mid_frame(16'h2000);
    run_dump(16'h2000, 16'd2, 1'b0);

    mem[16'h3000] = 8'h01; mem[16'h3001] = 8'h02; mem[16'h3002] = 8'hFF;
    run_dump(16'h3000, 16'd3, 1'b0);

    for (int r = 0; r < 6; r++) begin
      ra = 16'($urandom);
      rn = 16'($urandom_range(0, 4));
      run_dump(ra, rn, bit'(r % 2));
    end

    repeat (4) @(negedge clk_ram);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_ram_dump.md
Name: uart_ram_dump

Overview:
- UART transmitter that reads a block of program/video RAM and streams it out on a serial TX line, 8N1, LSB first.
- It is the readback path for the UART programming receiver, used to verify uploaded programs and dump screen pages.
- While dumping, it holds `ask_for_ram` high to suspend the CPU and owns the RAM read port.

Parameters:
- CLK_HZ, 25000000, frequency of clk_ram in Hz.
- BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 2).
- RAM_SETTLE, 2, clk_ram cycles between `ask_for_ram` rising and the first RAM read (CPU halt settle time).

Ports:
- clk_ram  input  1  system/RAM clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a dump when idle.
- start_addr  input  16  first RAM address; sampled on an accepted start.
- length  input  16  byte count; sampled on an accepted start.
- raddr  output  16  RAM read address.
- rdata  input  8  RAM read data, valid one cycle after raddr (synchronous RAM).
- ask_for_ram  output  1  high for the whole dump; suspends the CPU.
- serial_txd  output  1  UART TX line; idles high.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset values (asserted asynchronously):
  - serial_txd=1, ask_for_ram=0, busy=0, done=0, raddr=0.
  - FSM=IDLE; baud counter, bit counter and byte counter all 0.
- FSM states: IDLE, SETTLE, RD_ADDR, RD_DATA, SEND, FINISH.
- IDLE:
  - On start=1: latch start_addr into the address counter and length into the remaining counter.
  - Set busy=1 and ask_for_ram=1 on the next edge, then go to SETTLE.
  - start while busy is ignored.
- SETTLE: wait RAM_SETTLE cycles.
  - If remaining==0, go to FINISH.
  - Otherwise go to RD_ADDR.
- RD_ADDR: drive raddr = address counter for one cycle, then go to RD_DATA.
- RD_DATA: latch rdata into the 8-bit shift register and clear the baud counter.
  - Increment the address counter mod 2^16 (0xFFFF wraps to 0x0000).
  - Decrement remaining, then go to SEND.
- SEND: each bit lasts exactly CLKS_PER_BIT cycles, in order: start bit (0), data[0]..data[7], stop bit (1).
  - serial_txd is registered and changes only at bit boundaries.
  - At the end of the stop bit: if remaining != 0, go to RD_ADDR; otherwise go to FINISH.
  - The inter-frame gap is 2 cycles of idle-high (the RD_ADDR and RD_DATA cycles).
- FINISH: drop ask_for_ram, busy and done according to Optional Feature, then return to IDLE.
- Latency: start → first start-bit edge = 1 + RAM_SETTLE + 2 cycles.
- length=0: no frame is sent; done pulses, ask_for_ram is released, and serial_txd stays high.
- Mid-operation reset: outputs return immediately (asynchronously) to their reset values; the partial frame is abandoned and serial_txd goes high.
- rdata is sampled only in RD_DATA; changes on rdata at any other time have no effect.

Optional Feature:
- Macro: UART_DUMP_CHECKSUM_EN.
- Defined:
  - Keep an 8-bit running sum (mod 256) of all data bytes sent, cleared on accepted start.
  - After the last data byte, send one extra frame carrying the two's complement of that sum, so that data plus trailer sums to 0x00.
  - The trailer follows the same 2-cycle gap.
  - length=0 sends a single trailer of 0x00.
- Undefined: no trailer and no checksum logic.
- FINISH (both builds): on the cycle after the last stop bit, done=1 for one cycle, with ask_for_ram=0 and busy=0 on that same cycle.

Test Plan:
- Bench setup: CLK_HZ=1000000, BAUD=250000 (CLKS_PER_BIT=4), RAM_SETTLE=2.
- Single byte: RAM[0x0600]=0xA5, start with start_addr=0x0600, length=1.
  - ask_for_ram rises at cycle 1; start bit at cycle 5.
  - TX bits 1,0,1,0,0,1,0,1, each 4 clocks wide, then stop bit.
  - done at cycle 45; ask_for_ram falls the same cycle.
- Multi byte with address wrap: start_addr=0xFFFE, length=3, RAM = 0x11, 0x22, 0x33 at 0xFFFE, 0xFFFF, 0x0000.
  - raddr sequence is 0xFFFE, 0xFFFF, 0x0000; decoded bytes are 0x11, 0x22, 0x33.
  - Exactly 2 idle-high cycles between frames.
- Zero length: length=0 → no start bit; done pulses 4 cycles after start; serial_txd stays high throughout.
- Start while busy: pulse start again mid-frame with different start_addr → ignored; the original dump completes unchanged.
- Async reset mid-frame: assert reset_n=0 during data bit 3 → serial_txd=1, ask_for_ram=0, busy=0 before the next clock edge.
  - After release, a new start dumps correctly.
- Checksum (UART_DUMP_CHECKSUM_EN): bytes 0x01, 0x02, 0xFF → trailer frame 0xFE (sum 0x02).
